// File: rtl/sram_sp_mask_init_pkg.sv
// Shared types and constants for the single-port masked SRAM macro.
// Holds the controller state encoding, the legal read latencies and the mask-width check.
package sram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int LAT_1 = 1;
    localparam int LAT_2 = 2;

    function automatic bit mask_gran_ok(input int width, input int gran);
        return (gran > 0) && ((width % gran) == 0);
    endfunction

endpackage

// File: rtl/sram_sp_mask_init_if.sv
// Request/response bundle of the single-port masked SRAM.
// master drives requests, slave is the memory macro.
interface sram_sp_mask_init_if #(
    parameter int ADDR_W = 10,
    parameter int WIDTH  = 20,
    parameter int SEGS   = 1
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [ADDR_W-1:0] req_addr;
    logic [SEGS-1:0]   req_wmask;
    logic [WIDTH-1:0]  req_wdata;
    logic              resp_valid;
    logic [WIDTH-1:0]  resp_rdata;
    logic              init_done;

    modport master (
        output req_valid, req_wen, req_addr, req_wmask, req_wdata,
        input  req_ready, resp_valid, resp_rdata, init_done
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wmask, req_wdata,
        output req_ready, resp_valid, resp_rdata, init_done
    );
endinterface

// File: rtl/sram_sp_mask_init_array.sv
// Raw DEPTH x WIDTH storage with per-segment write enables and a registered read address.
// Storage is never reset; callers must keep addr below DEPTH whenever we or re is set.
module sram_sp_array #(
    parameter int DEPTH     = 1024,
    parameter int WIDTH     = 20,
    parameter int MASK_GRAN = 20,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int SEGS      = WIDTH / MASK_GRAN
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [SEGS-1:0]   wmask,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] addr_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int s = 0; s < SEGS; s++) begin
                if (wmask[s]) begin
                    mem[addr][s*MASK_GRAN +: MASK_GRAN] <= wdata[s*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
        if (re) begin
            addr_q <= addr;
        end
    end

    // Read-first: a write in the response cycle lands after this value is consumed.
    assign rdata = mem[addr_q];

endmodule

// File: rtl/sram_sp_mask_init.sv
// Single-port SRAM with masked writes, valid/ready requests, 1- or 2-cycle reads and held read data.
// Define SRAM_INIT_CLEAR_EN to zero every entry after reset before the first request is accepted.
module sram_sp_mask_init
    import sram_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int WIDTH     = 20,
    parameter int MASK_GRAN = 20,
    parameter int LATENCY   = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    sram_sp_mask_init_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int SEGS   = WIDTH / MASK_GRAN;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

`ifdef SRAM_INIT_CLEAR_EN
    localparam state_t RST_STATE = INIT;
`else
    localparam state_t RST_STATE = RUN;
`endif

    if (!mask_gran_ok(WIDTH, MASK_GRAN)) begin : g_bad_gran
        $error("WIDTH must be a multiple of MASK_GRAN");
    end
    if (LATENCY != LAT_1 && LATENCY != LAT_2) begin : g_bad_lat
        $error("LATENCY must be 1 or 2");
    end

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] sweep_cnt;
    logic              sweep_last;
    logic              sweeping;
    logic              run;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == INIT && sweep_last) begin
            state_d = RUN;
        end
    end

    always_comb begin
        sweeping = (state_q == INIT);
        run      = (state_q == RUN);
    end

`ifdef SRAM_INIT_CLEAR_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sweep_cnt <= '0;
        end else if (sweeping && !sweep_last) begin
            sweep_cnt <= sweep_cnt + ADDR_W'(1);
        end
    end

    assign sweep_last = (sweep_cnt == ADDR_W'(DEPTH - 1));
`else
    assign sweep_cnt  = '0;
    assign sweep_last = 1'b0;
`endif

    // ---- p0: request decode and array port mux
    logic              rd_p0;
    logic              wr_p0;
    logic              inrng_p0;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [SEGS-1:0]   arr_wmask;
    logic [WIDTH-1:0]  arr_wdata;
    logic [WIDTH-1:0]  arr_rdata;

    always_comb begin
        inrng_p0  = ({1'b0, bus.req_addr} < DEPTH_L);
        rd_p0     = bus.req_valid && run && !bus.req_wen;
        wr_p0     = bus.req_valid && run && bus.req_wen;
        arr_we    = wr_p0 && inrng_p0;
        arr_addr  = inrng_p0 ? bus.req_addr : '0;
        arr_wmask = bus.req_wmask;
        arr_wdata = bus.req_wdata;
        if (sweeping) begin
            arr_we    = 1'b1;
            arr_addr  = sweep_cnt;
            arr_wmask = '1;
            arr_wdata = '0;
        end
    end

    sram_sp_array #(
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .MASK_GRAN (MASK_GRAN),
        .ADDR_W    (ADDR_W),
        .SEGS      (SEGS)
    ) u_array (
        .clk   (clock),
        .we    (arr_we),
        .re    (rd_p0),
        .addr  (arr_addr),
        .wmask (arr_wmask),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    // ---- p1: array output, out-of-range reads forced to zero
    logic             vld_p1;
    logic             oor_p1;
    logic [WIDTH-1:0] data_p1;
    logic             out_vld;
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] hold_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1 <= 1'b0;
            oor_p1 <= 1'b0;
        end else begin
            vld_p1 <= rd_p0;
            if (rd_p0) begin
                oor_p1 <= !inrng_p0;
            end
        end
    end

    assign data_p1 = oor_p1 ? '0 : arr_rdata;

    // ---- p2: optional output register stage
    if (LATENCY == LAT_2) begin : g_lat2
        logic             vld_p2;
        logic [WIDTH-1:0] data_p2;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                vld_p2 <= 1'b0;
            end else begin
                vld_p2 <= vld_p1;
            end
        end

        always_ff @(posedge clock) begin
            if (vld_p1) begin
                data_p2 <= data_p1;
            end
        end

        assign out_vld  = vld_p2;
        assign out_data = data_p2;
    end else begin : g_lat1
        assign out_vld  = vld_p1;
        assign out_data = data_p1;
    end

    // The hold register keeps the last response so later writes cannot disturb the output.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= '0;
        end else if (out_vld) begin
            hold_q <= out_data;
        end
    end

    assign bus.req_ready  = run;
    assign bus.init_done  = run;
    assign bus.resp_valid = out_vld;
    assign bus.resp_rdata = out_vld ? out_data : hold_q;

endmodule

// File: tb/tb_sram_sp_mask_init.sv
// Bench for sram_sp_mask_init: a DEPTH=12/LATENCY=1 and a DEPTH=16/LATENCY=2 instance share stimulus.
// Read expectations go into per-instance queues and are checked as responses appear.
module tb_sram_sp_mask_init;

`ifdef SRAM_INIT_CLEAR_EN
    localparam logic INIT_RDY = 1'b0;
`else
    localparam logic INIT_RDY = 1'b1;
`endif

    typedef struct {
        logic        wen;
        logic [3:0]  addr;
        logic [3:0]  mask;
        logic [19:0] data;
        logic [19:0] exp_a;
        logic [19:0] exp_b;
    } vec_t;

    typedef struct {
        int          due;
        logic [19:0] data;
    } exp_t;

    logic        clk;
    logic        reset_n;
    int          cyc;
    int          total;
    int          bad;
    exp_t        qA[$];
    exp_t        qB[$];
    exp_t        eA;
    exp_t        eB;
    logic [19:0] lastA;
    logic [19:0] lastB;
    vec_t        tv[16];

    sram_sp_mask_init_if #(.ADDR_W(4), .WIDTH(20), .SEGS(4)) ifA ();
    sram_sp_mask_init_if #(.ADDR_W(4), .WIDTH(20), .SEGS(4)) ifB ();

    sram_sp_mask_init #(.DEPTH(12), .WIDTH(20), .MASK_GRAN(5), .LATENCY(1)) dut_a (
        .clock   (clk),
        .reset_n (reset_n),
        .bus     (ifA)
    );

    sram_sp_mask_init #(.DEPTH(16), .WIDTH(20), .MASK_GRAN(5), .LATENCY(2)) dut_b (
        .clock   (clk),
        .reset_n (reset_n),
        .bus     (ifB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drv(input logic v, input logic w, input logic [3:0] a, input logic [3:0] m,
                       input logic [19:0] d);
        ifA.req_valid = v; ifA.req_wen = w; ifA.req_addr = a; ifA.req_wmask = m; ifA.req_wdata = d;
        ifB.req_valid = v; ifB.req_wen = w; ifB.req_addr = a; ifB.req_wmask = m; ifB.req_wdata = d;
    endtask

    task automatic idle(input int n);
        drv(1'b0, 1'b0, 4'h0, 4'h0, 20'h0);
        repeat (n) @(negedge clk);
    endtask

    // Called at a falling edge; presents one request for the next rising edge.
    task automatic op(input logic wen, input logic [3:0] addr, input logic [3:0] mask,
                      input logic [19:0] data, input logic [19:0] ea, input logic [19:0] eb);
        int n = 0;
        while (!(ifA.req_ready && ifB.req_ready)) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                chk("ready_timeout", 32'(ifA.req_ready & ifB.req_ready), 1);
                break;
            end
        end
        drv(1'b1, wen, addr, mask, data);
        if (!wen) begin
            qA.push_back('{due: cyc + 1, data: ea});
            qB.push_back('{due: cyc + 2, data: eb});
        end
        @(negedge clk);
    endtask

    task automatic reset_now();
        reset_n = 1'b0;
        drv(1'b0, 1'b0, 4'h0, 4'h0, 20'h0);
        qA.delete();
        qB.delete();
        lastA = '0;
        lastB = '0;
        #1;
        chk("rst_A_resp_valid", 32'(ifA.resp_valid), 0);
        chk("rst_B_resp_valid", 32'(ifB.resp_valid), 0);
        chk("rst_A_resp_rdata", 32'(ifA.resp_rdata), 0);
        chk("rst_B_resp_rdata", 32'(ifB.resp_rdata), 0);
        chk("rst_A_req_ready", 32'(ifA.req_ready), 32'(INIT_RDY));
        chk("rst_B_req_ready", 32'(ifB.req_ready), 32'(INIT_RDY));
        chk("rst_B_init_done", 32'(ifB.init_done), 32'(INIT_RDY));
    endtask

    // Called at the falling edge where reset_n is released.
    task automatic after_release();
`ifdef SRAM_INIT_CLEAR_EN
        for (int k = 0; k <= 16; k++) begin
            chk("A_ready_sweep", 32'(ifA.req_ready), 32'(k >= 12));
            chk("B_ready_sweep", 32'(ifB.req_ready), 32'(k >= 16));
            chk("B_init_done_sweep", 32'(ifB.init_done), 32'(k >= 16));
            @(negedge clk);
        end
`else
        chk("A_ready_first", 32'(ifA.req_ready), 1);
        chk("B_ready_first", 32'(ifB.req_ready), 1);
        chk("B_init_done_first", 32'(ifB.init_done), 1);
`endif
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (ifA.resp_valid) begin
                if (qA.size() == 0) begin
                    chk("A_unexpected_vld", 32'(ifA.resp_valid), 0);
                end else begin
                    eA = qA.pop_front();
                    chk("A_rdata", 32'(ifA.resp_rdata), 32'(eA.data));
                    chk("A_latency", cyc, eA.due);
                end
                lastA = ifA.resp_rdata;
            end else begin
                chk("A_hold", 32'(ifA.resp_rdata), 32'(lastA));
                if (qA.size() != 0 && qA[0].due <= cyc) begin
                    chk("A_missing_vld", 32'(ifA.resp_valid), 1);
                    void'(qA.pop_front());
                end
            end
            if (ifB.resp_valid) begin
                if (qB.size() == 0) begin
                    chk("B_unexpected_vld", 32'(ifB.resp_valid), 0);
                end else begin
                    eB = qB.pop_front();
                    chk("B_rdata", 32'(ifB.resp_rdata), 32'(eB.data));
                    chk("B_latency", cyc, eB.due);
                end
                lastB = ifB.resp_rdata;
            end else begin
                chk("B_hold", 32'(ifB.resp_rdata), 32'(lastB));
                if (qB.size() != 0 && qB[0].due <= cyc) begin
                    chk("B_missing_vld", 32'(ifB.resp_valid), 1);
                    void'(qB.pop_front());
                end
            end
        end
    end

    initial begin
        // A has DEPTH=12 so address 13 is dropped there and reads back as zero.
        tv[0]  = '{1'b1, 4'd7,  4'hF, 20'hABCDE, 20'h00000, 20'h00000};
        tv[1]  = '{1'b1, 4'd7,  4'h2, 20'h00000, 20'h00000, 20'h00000};
        tv[2]  = '{1'b0, 4'd7,  4'h0, 20'h00000, 20'hABC1E, 20'hABC1E};
        tv[3]  = '{1'b1, 4'd1,  4'hF, 20'h11111, 20'h00000, 20'h00000};
        tv[4]  = '{1'b1, 4'd2,  4'hF, 20'h22222, 20'h00000, 20'h00000};
        tv[5]  = '{1'b1, 4'd3,  4'hF, 20'h33333, 20'h00000, 20'h00000};
        tv[6]  = '{1'b1, 4'd13, 4'hF, 20'h5A5A5, 20'h00000, 20'h00000};
        tv[7]  = '{1'b0, 4'd1,  4'h0, 20'h00000, 20'h11111, 20'h11111};
        tv[8]  = '{1'b0, 4'd2,  4'h0, 20'h00000, 20'h22222, 20'h22222};
        tv[9]  = '{1'b0, 4'd3,  4'h0, 20'h00000, 20'h33333, 20'h33333};
        tv[10] = '{1'b0, 4'd13, 4'h0, 20'h00000, 20'h00000, 20'h5A5A5};
        tv[11] = '{1'b0, 4'd1,  4'h0, 20'h00000, 20'h11111, 20'h11111};
        tv[12] = '{1'b1, 4'd3,  4'h0, 20'hFFFFF, 20'h00000, 20'h00000};
        tv[13] = '{1'b0, 4'd3,  4'h0, 20'h00000, 20'h33333, 20'h33333};
        tv[14] = '{1'b1, 4'd3,  4'h5, 20'h0F0F0, 20'h00000, 20'h00000};
        tv[15] = '{1'b0, 4'd3,  4'h0, 20'h00000, 20'h37330, 20'h37330};

        cyc     = 0;
        total   = 0;
        bad     = 0;
        lastA   = '0;
        lastB   = '0;
        reset_n = 1'b1;
        drv(1'b0, 1'b0, 4'h0, 4'h0, 20'h0);
        #1;
        reset_now();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        after_release();

`ifdef SRAM_INIT_CLEAR_EN
        for (int k = 0; k < 16; k++) begin
            op(1'b0, 4'(k), 4'h0, 20'h0, 20'h0, 20'h0);
        end
        idle(4);
`endif

        for (int i = 0; i < 16; i++) begin
            op(tv[i].wen, tv[i].addr, tv[i].mask, tv[i].data, tv[i].exp_a, tv[i].exp_b);
        end
        idle(4);

        op(1'b1, 4'd3, 4'hF, 20'h00ABC, 20'h0, 20'h0);
        idle(3);
        chk("A_hold_after_rewrite", 32'(ifA.resp_rdata), 32'h37330);
        chk("B_hold_after_rewrite", 32'(ifB.resp_rdata), 32'h37330);

        // Reset while a read is in flight: A's response is showing, B's is still in the pipe.
        drv(1'b1, 1'b0, 4'd7, 4'h0, 20'h0);
        @(posedge clk);
        #2;
        reset_now();
        @(negedge clk);
        reset_n = 1'b1;

        // Reset in the middle of the sweep (or during normal operation without it).
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2;
        reset_now();
        @(negedge clk);
        reset_n = 1'b1;
        after_release();

        op(1'b1, 4'd5, 4'hF, 20'h12345, 20'h0, 20'h0);
        op(1'b0, 4'd5, 4'h0, 20'h0, 20'h12345, 20'h12345);
        idle(6);

        chk("A_queue_drained", qA.size(), 0);
        chk("B_queue_drained", qB.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
